// File: rtl/nand_gate_stream.sv
// nand_gate_stream: NAND/AND reduction of NUM_IN operands
// feeding a DEPTH-entry result FIFO with valid/ready on both sides.
module nand_gate_stream #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 2,
  parameter int DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mode,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_IN*WIDTH-1:0]   a,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          y,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic [15:0]               results
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [LW-1:0]    r_level;
  logic [15:0]      r_results;

  logic [WIDTH-1:0] w_red;
  logic [WIDTH-1:0] w_res;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;

  always_comb begin
    w_red = '1;
    for (int i = 0; i < NUM_IN; i++) begin
      w_red = w_red & a[i*WIDTH +: WIDTH];
    end
  end

  assign w_res   = mode ? w_red : ~w_red;
  assign w_full  = (r_level == LW'(DEPTH));
  assign w_empty = (r_level == '0);

  // in_ready held low through reset; never looks at out_ready
  assign in_ready  = rst & ~w_full;
  assign out_valid = ~w_empty;
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  assign y       = w_empty ? '0 : r_mem[r_rptr];
  assign level   = r_level;
  assign results = r_results;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_res;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_level   <= '0;
      r_results <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr    <= r_rptr + AW'(1);
        r_results <= r_results + 16'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: tb/tb_nand_gate_stream.sv
// tb_nand_gate_stream: scoreboard bench for nand_gate_stream
// with directed boundary checks around reset, full and wrap.
module tb_nand_gate_stream;

  logic        clk;
  logic        rst;
  logic        mode;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  y;
  logic [2:0]  level;
  logic [15:0] results;

  int n_chk;
  int n_fail;
  int sb_pops;
  int acc;
  int guard;
  logic [7:0] sbq[$];

  nand_gate_stream #(.WIDTH(8), .NUM_IN(2), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .a(a),
    .out_valid(out_valid), .out_ready(out_ready), .y(y),
    .level(level), .results(results)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model(input logic [15:0] op,
                                       input logic m);
    logic [7:0] r;
    r = op[7:0] & op[15:8];
    return m ? r : ~r;
  endfunction

  // handshakes seen at negedge complete on the following posedge
  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      sbq.delete();
      sb_pops = 0;
    end else begin
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          chk("sb_y", y, sbq.pop_front());
        end
        sb_pops++;
      end
      if (in_valid && in_ready) sbq.push_back(model(a, mode));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 0;
    out_ready = 0;
    rst = 0;
    step();
    step();
    rst = 1;
    step();
  endtask

  task automatic push(input logic [7:0] a0,
                      input logic [7:0] a1,
                      input logic m);
    a = {a1, a0};
    mode = m;
    in_valid = 1;
    step();
    in_valid = 0;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst = 0;
    in_valid = 0;
    out_ready = 0;
    mode = 0;
    a = '0;

    // 1: reset values with toggling inputs
    for (int i = 0; i < 4; i++) begin
      a = 16'($urandom);
      mode = 1'($urandom);
      in_valid = 1'($urandom);
      out_ready = 1'($urandom);
      step();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_y", y, 0);
      chk("rst_level", level, 0);
      chk("rst_results", results, 0);
    end
    in_valid = 0;
    out_ready = 0;
    rst = 1;
    step();
    chk("post_rst_in_ready", in_ready, 1);

    // 2: single NAND
    push(8'hF0, 8'hCC, 0);
    chk("t2_out_valid", out_valid, 1);
    chk("t2_y", y, 8'h3F);
    chk("t2_level", level, 1);
    out_ready = 1;
    step();
    out_ready = 0;
    chk("t2_pop_valid", out_valid, 0);
    chk("t2_pop_y", y, 0);
    chk("t2_results", results, 1);

    // 3: AND mode and ordering
    do_reset();
    push(8'hFF, 8'hAA, 1);
    push(8'h0F, 8'h0F, 0);
    push(8'h00, 8'hFF, 0);
    chk("t3_level", level, 3);
    chk("t3_y0", y, 8'hAA);
    out_ready = 1;
    step();
    chk("t3_y1", y, 8'hF0);
    step();
    chk("t3_y2", y, 8'hFF);
    step();
    out_ready = 0;
    chk("t3_empty", out_valid, 0);
    chk("t3_results", results, 3);

    // 4: full boundary
    do_reset();
    acc = 0;
    a = 16'h5A3C;
    mode = 0;
    in_valid = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (in_ready) acc++;
      step();
    end
    chk("t4_accepts", acc, 4);
    chk("t4_level_full", level, 4);
    chk("t4_in_ready_full", in_ready, 0);
    out_ready = 1;
    step();
    out_ready = 0;
    in_valid = 0;
    chk("t4_level_pop", level, 3);
    step();
    chk("t4_level_hold", level, 3);
    chk("t4_in_ready", in_ready, 1);

    // 5: simultaneous push/pop across pointer wrap
    do_reset();
    push(8'h12, 8'h34, 0);
    push(8'hF3, 8'h7E, 1);
    chk("t5_level_start", level, 2);
    in_valid = 1;
    out_ready = 1;
    for (int i = 0; i < 10; i++) begin
      a = 16'($urandom);
      mode = 1'($urandom);
      step();
      chk("t5_level", level, 2);
    end
    in_valid = 0;
    guard = 0;
    while (out_valid && guard < 10) begin
      step();
      guard++;
    end
    out_ready = 0;
    chk("t5_drained", out_valid, 0);
    chk("t5_sb_empty", sbq.size(), 0);
    chk("t5_results", results, 12);

    // 6a: asynchronous reset mid-stream
    do_reset();
    push(8'h01, 8'h02, 0);
    push(8'h03, 8'h04, 1);
    push(8'h05, 8'h06, 0);
    chk("t6_level3", level, 3);
    #1;
    rst = 0;
    #1;
    chk("t6_out_valid", out_valid, 0);
    chk("t6_y", y, 0);
    chk("t6_level", level, 0);
    chk("t6_results", results, 0);
    chk("t6_in_ready", in_ready, 0);
    #1;
    rst = 1;
    step();
    chk("t6_after_level", level, 0);

    // 6b: results counter wrap
    do_reset();
    in_valid = 1;
    out_ready = 1;
    guard = 0;
    while (sb_pops < 65537 && guard < 70000) begin
      a = 16'($urandom);
      mode = 1'($urandom);
      step();
      guard++;
    end
    in_valid = 0;
    out_ready = 0;
    chk("t6_wrap_results", results, 16'h0001);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
